// File: rtl/fifo_pkg.sv
// Shared definitions for the multi-lane FIFO: default index type and the
// modular lane-address helper used by both the write and read lanes.
package fifo_pkg;

    localparam int unsigned FIFO_LG_D = 3;

    // Read/write index and occupancy type for the default depth: one bit wider
    // than the storage address so that full and empty remain distinguishable.
    typedef logic [FIFO_LG_D:0] fifo_idx_t;

    // Storage address of lane 'lane' relative to index 'idx': (idx + lane) mod 2**lg_d.
    function automatic int unsigned lane_addr(input int unsigned idx,
                                              input int unsigned lane,
                                              input int unsigned lg_d);
        return (idx + lane) & ((32'd1 << lg_d) - 32'd1);
    endfunction

endpackage

// File: rtl/mport_fifo_ram.sv
// D x W storage with NP independently enabled write ports and NR
// asynchronous read ports. Storage is never reset.
module mport_fifo_ram #(
    parameter int W    = 32,
    parameter int LG_D = 3,
    parameter int NP   = 2,
    parameter int NR   = 2
) (
    input  logic                 clk,
    input  logic [NP-1:0]        i_we,
    input  logic [NP*LG_D-1:0]   i_waddr,
    input  logic [NP*W-1:0]      i_wdata,
    input  logic [NR*LG_D-1:0]   i_raddr,
    output logic [NR*W-1:0]      o_rdata
);

    localparam int D = 1 << LG_D;

    logic [W-1:0] r_mem [D];

    // Write every enabled lane; legal pushes never target the same address twice.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NP; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr[i*LG_D +: LG_D]] <= i_wdata[i*W +: W];
            end
        end
    end

    // Combinational read of each lane's addressed entry.
    always_comb begin
        o_rdata = '0;
        for (int j = 0; j < NR; j++) begin
            o_rdata[j*W +: W] = r_mem[i_raddr[j*LG_D +: LG_D]];
        end
    end

endmodule

// File: rtl/mport_fifo.sv
// Multi-lane FIFO: up to NP pushes and NR pops per clock, NR head entries
// exposed, occupancy/free counts, synchronous flush and sticky error flags.
// Outputs depend only on registered state (no same-cycle bypass).
module mport_fifo
    import fifo_pkg::*;
#(
    parameter int W    = 32,
    parameter int LG_D = 3,
    parameter int NP   = 2,
    parameter int NR   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NP*W-1:0]            in,
    input  logic [$clog2(NP+1)-1:0]    push_cnt,
    input  logic [$clog2(NR+1)-1:0]    pop_cnt,
    output logic [NR*W-1:0]            out,
    output logic [NR-1:0]              out_valid,
    output logic [LG_D:0]              count,
    output logic [LG_D:0]              free,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int D   = 1 << LG_D;
    localparam int CW  = LG_D + 1;
    localparam int PCW = $clog2(NP + 1);
    localparam int RCW = $clog2(NR + 1);

    logic [CW-1:0]      r_rd_idx;
    logic [CW-1:0]      r_wr_idx;
    logic               r_overflow;
    logic               r_underflow;

    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_free;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_push_go;
    logic [NP-1:0]      w_we;
    logic [NP*LG_D-1:0] w_waddr;
    logic [NR*LG_D-1:0] w_raddr;

    // Occupancy is the modular index difference; the extra MSB separates full from empty.
    assign w_count = r_wr_idx - r_rd_idx;
    assign w_free  = CW'(D) - w_count;

    // Legality is judged on the current cycle's occupancy only: a same-cycle
    // pop does not make room for a push, nor does a push feed a pop.
    assign w_push_ok = (CW'(push_cnt) <= w_free);
    assign w_pop_ok  = (CW'(pop_cnt) <= w_count);
    assign w_push_go = !reset && !flush && w_push_ok;

    for (genvar i = 0; i < NP; i++) begin : g_wr_lane
        assign w_we[i]                  = w_push_go && (push_cnt > PCW'(i));
        assign w_waddr[i*LG_D +: LG_D]  = LG_D'(lane_addr(32'(r_wr_idx), i, LG_D));
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd_lane
        assign w_raddr[j*LG_D +: LG_D]  = LG_D'(lane_addr(32'(r_rd_idx), j, LG_D));
        assign out_valid[j]             = (w_count > CW'(j));
    end

    mport_fifo_ram #(
        .W    (W),
        .LG_D (LG_D),
        .NP   (NP),
        .NR   (NR)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (in),
        .i_raddr (w_raddr),
        .o_rdata (out)
    );

    // Index and sticky-flag update: reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_idx    <= '0;
            r_wr_idx    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_rd_idx    <= r_wr_idx;
        end else begin
            if (w_push_ok) begin
                r_wr_idx <= r_wr_idx + CW'(push_cnt);
            end else begin
                r_overflow <= 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_idx <= r_rd_idx + CW'(pop_cnt);
            end else begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign count     = w_count;
    assign free      = w_free;
    assign empty     = (w_count == '0);
    assign full      = w_count[CW-1];
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

    a_push_cnt_range: assert property (@(posedge clk) disable iff (reset) push_cnt <= PCW'(NP));
    a_pop_cnt_range:  assert property (@(posedge clk) disable iff (reset) pop_cnt <= RCW'(NR));
    a_count_range:    assert property (@(posedge clk) disable iff (reset) w_count <= CW'(D));

endmodule
